// File: rtl/retire_order_tracker.sv
// retire_order_tracker: records issued IDs in program order, collects
// out-of-order writeback completions and retires up to RETIRE_PORTS
// consecutive completed IDs from the queue head each cycle.
module retire_order_tracker #(
  parameter int MAX_IDS      = 8,
  parameter int WB_PORTS     = 2,
  parameter int RETIRE_PORTS = 2,
  localparam int ID_W        = $clog2(MAX_IDS),
  localparam int RC_W        = $clog2(RETIRE_PORTS+1)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 issue_valid,
  input  logic [ID_W-1:0]                      issue_id,
  input  logic                                 issue_uses_rd,
  output logic                                 issue_ready,
  input  logic [WB_PORTS-1:0]                  wb_valid,
  input  logic [WB_PORTS-1:0][ID_W-1:0]        wb_id,
  output logic [RETIRE_PORTS-1:0]              retired,
  output logic [RETIRE_PORTS-1:0][ID_W-1:0]    ids_retiring,
  output logic [RETIRE_PORTS-1:0]              retired_uses_rd,
  output logic [RC_W-1:0]                      retire_count,
  output logic [ID_W:0]                        inflight_count,
  output logic                                 empty,
  output logic                                 protocol_error
);

  logic [MAX_IDS-1:0][ID_W-1:0] ent_id;
  logic [MAX_IDS-1:0]           ent_rd;
  logic [ID_W-1:0]              head, tail;
  logic [ID_W:0]                count;
  logic [MAX_IDS-1:0]           inflight, done;

  logic [MAX_IDS-1:0]           iss_set, wb_set, ret_clr;
  logic [WB_PORTS-1:0]          wb_legal;
  logic                         iss_acc, iss_bad, wb_bad, wb_dup;
  logic [ID_W:0]                rc_ext;

  assign issue_ready    = (count < (ID_W+1)'(MAX_IDS));
  assign empty          = (count == '0);
  assign inflight_count = count;
  assign rc_ext         = (ID_W+1)'(retire_count);

  // Issue acceptance: a free slot and an ID not already tracked
  assign iss_acc = issue_valid & issue_ready & ~inflight[issue_id];
  assign iss_bad = issue_valid & ~iss_acc;
  assign iss_set = iss_acc ? (MAX_IDS'(1) << issue_id) : '0;

  // Per-port completion legality: ID must be inflight and not yet done
  for (genvar p = 0; p < WB_PORTS; p++) begin : g_wb
    assign wb_legal[p] = wb_valid[p] & inflight[wb_id[p]] & ~done[wb_id[p]];
  end

  // Merge completions into a done mask; flag bad and duplicate strobes
  always_comb begin
    wb_set = '0;
    wb_bad = 1'b0;
    wb_dup = 1'b0;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_legal[p]) wb_set[wb_id[p]] = 1'b1;
      if (wb_valid[p] & ~wb_legal[p]) wb_bad = 1'b1;
      for (int q = 0; q < p; q++)
        if (wb_legal[p] & wb_legal[q] & (wb_id[p] == wb_id[q])) wb_dup = 1'b1;
    end
  end

  // Retire chain from head: stops at the first not-done or unoccupied slot
  always_comb begin : retire_chain
    logic            ok;
    logic [ID_W-1:0] idx;
    ok              = 1'b1;
    idx             = '0;
    retire_count    = '0;
    ret_clr         = '0;
    retired         = '0;
    ids_retiring    = '0;
    retired_uses_rd = '0;
    for (int k = 0; k < RETIRE_PORTS; k++) begin
      idx                = head + ID_W'(k);
      ok                 = ok & ((ID_W+1)'(k) < count) & done[ent_id[idx]];
      retired[k]         = ok;
      ids_retiring[k]    = ent_id[idx];
      retired_uses_rd[k] = ent_rd[idx];
      if (ok) ret_clr[ent_id[idx]] = 1'b1;
      retire_count       = retire_count + RC_W'(ok);
    end
  end

  // Queue, pointers, per-ID tracking bits and sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_id         <= '0;
      ent_rd         <= '0;
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      inflight       <= '0;
      done           <= '0;
      protocol_error <= 1'b0;
    end else begin
      if (iss_acc) begin
        ent_id[tail] <= issue_id;
        ent_rd[tail] <= issue_uses_rd;
        tail         <= tail + ID_W'(1);
      end
      head     <= head + rc_ext[ID_W-1:0];
      count    <= count + (ID_W+1)'(iss_acc) - rc_ext;
      // issue, completion and retire masks touch disjoint IDs by construction
      inflight <= (inflight | iss_set) & ~ret_clr;
      done     <= (done | wb_set) & ~ret_clr & ~iss_set;
      if (iss_bad | wb_bad | wb_dup) protocol_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_retire_order_tracker.sv
// Directed bench for retire_order_tracker with hand-computed expectations.
module tb_retire_order_tracker;
  localparam int MAX_IDS = 8, WB_PORTS = 2, RETIRE_PORTS = 2;
  localparam int ID_W = 3, RC_W = 2;

  logic                          clk = 1'b0;
  logic                          rst_n = 1'b0;
  logic                          issue_valid = 1'b0;
  logic [ID_W-1:0]               issue_id = '0;
  logic                          issue_uses_rd = 1'b0;
  logic                          issue_ready;
  logic [WB_PORTS-1:0]           wb_valid = '0;
  logic [WB_PORTS-1:0][ID_W-1:0] wb_id = '0;
  logic [RETIRE_PORTS-1:0]       retired;
  logic [RETIRE_PORTS-1:0][ID_W-1:0] ids_retiring;
  logic [RETIRE_PORTS-1:0]       retired_uses_rd;
  logic [RC_W-1:0]               retire_count;
  logic [ID_W:0]                 inflight_count;
  logic                          empty, protocol_error;

  int n_chk = 0, n_fail = 0;

  retire_order_tracker #(.MAX_IDS(MAX_IDS), .WB_PORTS(WB_PORTS), .RETIRE_PORTS(RETIRE_PORTS)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_id(issue_id), .issue_uses_rd(issue_uses_rd),
    .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_id(wb_id),
    .retired(retired), .ids_retiring(ids_retiring), .retired_uses_rd(retired_uses_rd),
    .retire_count(retire_count), .inflight_count(inflight_count),
    .empty(empty), .protocol_error(protocol_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock; outputs are then sampled 1ns after the edge
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic iss(input logic v, input int id, input logic rd);
    issue_valid = v; issue_id = ID_W'(id); issue_uses_rd = rd;
  endtask

  task automatic wb(input logic v0, input int i0, input logic v1, input int i1);
    wb_valid = {v1, v0}; wb_id[0] = ID_W'(i0); wb_id[1] = ID_W'(i1);
  endtask

  task automatic idle();
    iss(1'b0, 0, 1'b0); wb(1'b0, 0, 1'b0, 0);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0; #2;
    @(negedge clk); rst_n = 1'b1;
    step();
  endtask

  task automatic chk_reset_vals(input string t);
    chk({t, "_ready"}, 32'(issue_ready), 1);
    chk({t, "_empty"}, 32'(empty), 1);
    chk({t, "_rc"}, 32'(retire_count), 0);
    chk({t, "_ret"}, 32'(retired), 0);
    chk({t, "_cnt"}, 32'(inflight_count), 0);
    chk({t, "_perr"}, 32'(protocol_error), 0);
  endtask

  initial begin
    // reset held low, then one idle cycle after release
    #3;
    chk_reset_vals("rst_low");
    @(negedge clk); rst_n = 1'b1;
    step();
    chk_reset_vals("rst_idle");

    // in-order: issue 0,1,2 then complete (0,1) and (2)
    iss(1'b1, 0, 1'b1); step();
    chk("io_cnt1", 32'(inflight_count), 1);
    iss(1'b1, 1, 1'b0); step();
    iss(1'b1, 2, 1'b1); step();
    iss(1'b0, 0, 1'b0);
    chk("io_cnt3", 32'(inflight_count), 3);
    chk("io_norc", 32'(retire_count), 0);
    wb(1'b1, 0, 1'b1, 1); step();
    chk("io_ret01", 32'(retired), 2'b11);
    chk("io_id0", 32'(ids_retiring[0]), 0);
    chk("io_id1", 32'(ids_retiring[1]), 1);
    chk("io_rc2", 32'(retire_count), 2);
    chk("io_rd", 32'(retired_uses_rd), 2'b01);
    wb(1'b1, 2, 1'b0, 0); step();
    wb(1'b0, 0, 1'b0, 0);
    chk("io_ret2", 32'(retired), 2'b01);
    chk("io_id2", 32'(ids_retiring[0]), 2);
    chk("io_rc1", 32'(retire_count), 1);
    chk("io_rd2", 32'(retired_uses_rd[0]), 1);
    step();
    chk("io_empty", 32'(empty), 1);
    chk("io_noret", 32'(retired), 0);
    chk("io_perr", 32'(protocol_error), 0);

    // out-of-order: issue 0..3, complete 3,2 then 1, then 0
    for (int i = 0; i < 4; i++) begin iss(1'b1, i, 1'b0); step(); end
    iss(1'b0, 0, 1'b0);
    wb(1'b1, 3, 1'b1, 2); step();
    wb(1'b1, 1, 1'b0, 0); step();
    wb(1'b0, 0, 1'b0, 0);
    chk("ooo_hold_rc", 32'(retire_count), 0);
    chk("ooo_hold_cnt", 32'(inflight_count), 4);
    wb(1'b1, 0, 1'b0, 0); step();
    wb(1'b0, 0, 1'b0, 0);
    chk("ooo_rc_a", 32'(retire_count), 2);
    chk("ooo_id_a0", 32'(ids_retiring[0]), 0);
    chk("ooo_id_a1", 32'(ids_retiring[1]), 1);
    step();
    chk("ooo_rc_b", 32'(retire_count), 2);
    chk("ooo_id_b0", 32'(ids_retiring[0]), 2);
    chk("ooo_id_b1", 32'(ids_retiring[1]), 3);
    step();
    chk("ooo_empty", 32'(empty), 1);
    chk("ooo_perr", 32'(protocol_error), 0);

    // full and wrap: issue 0..7
    for (int i = 0; i < 8; i++) begin iss(1'b1, i, 1'b0); step(); end
    iss(1'b0, 0, 1'b0);
    chk("full_ready", 32'(issue_ready), 0);
    chk("full_cnt", 32'(inflight_count), 8);
    wb(1'b1, 0, 1'b0, 0); step();
    wb(1'b0, 0, 1'b0, 0);
    chk("full_ret0", 32'(retired), 2'b01);
    chk("full_id0", 32'(ids_retiring[0]), 0);
    chk("full_ready_still0", 32'(issue_ready), 0);
    iss(1'b1, 0, 1'b1); step();   // rejected: queue still full this cycle
    iss(1'b0, 0, 1'b0);
    chk("full_rej_perr", 32'(protocol_error), 1);
    chk("full_rej_cnt", 32'(inflight_count), 7);
    chk("full_slot_free", 32'(issue_ready), 1);
    iss(1'b1, 0, 1'b1); step();
    iss(1'b0, 0, 1'b0);
    chk("wrap_cnt", 32'(inflight_count), 8);
    chk("wrap_ready", 32'(issue_ready), 0);
    wb(1'b1, 1, 1'b1, 2); step();
    wb(1'b1, 3, 1'b1, 4); step();
    wb(1'b1, 5, 1'b1, 6); step();
    wb(1'b1, 7, 1'b1, 0); step();
    wb(1'b0, 0, 1'b0, 0);
    chk("wrap_rc", 32'(retire_count), 2);
    chk("wrap_id0", 32'(ids_retiring[0]), 7);
    chk("wrap_id1", 32'(ids_retiring[1]), 0);
    chk("wrap_rd1", 32'(retired_uses_rd[1]), 1);
    step();
    chk("wrap_empty", 32'(empty), 1);

    // simultaneous issue and retire
    for (int i = 1; i < 4; i++) begin iss(1'b1, i, 1'b0); step(); end
    iss(1'b0, 0, 1'b0);
    wb(1'b1, 1, 1'b1, 2); step();
    wb(1'b0, 0, 1'b0, 0);
    chk("sim_rc", 32'(retire_count), 2);
    chk("sim_cnt3", 32'(inflight_count), 3);
    iss(1'b1, 5, 1'b0); step();
    iss(1'b0, 0, 1'b0);
    chk("sim_cnt2", 32'(inflight_count), 2);
    chk("sim_blocked", 32'(retire_count), 0);

    // errors: wb of a non-inflight ID leaves state alone
    do_reset();
    chk("err_rst_perr", 32'(protocol_error), 0);
    for (int i = 0; i < 4; i++) begin iss(1'b1, i, 1'b0); step(); end
    iss(1'b0, 0, 1'b0);
    wb(1'b1, 6, 1'b0, 0); step();
    wb(1'b0, 0, 1'b0, 0);
    chk("err_wb6_perr", 32'(protocol_error), 1);
    chk("err_wb6_cnt", 32'(inflight_count), 4);
    chk("err_wb6_rc", 32'(retire_count), 0);
    wb(1'b1, 0, 1'b0, 0); step();
    wb(1'b0, 0, 1'b0, 0);
    chk("err_pre_rst_ret", 32'(retired), 2'b01);
    // asynchronous reset mid-cycle drops everything at once
    #2; rst_n = 1'b0; #1;
    chk_reset_vals("async_rst");
    @(negedge clk); rst_n = 1'b1;
    step();

    // duplicate same-cycle wb: error flagged, completion still recorded once
    iss(1'b1, 4, 1'b1); step();
    iss(1'b0, 0, 1'b0);
    chk("dup_pre_perr", 32'(protocol_error), 0);
    wb(1'b1, 4, 1'b1, 4); step();
    wb(1'b0, 0, 1'b0, 0);
    chk("dup_perr", 32'(protocol_error), 1);
    chk("dup_rc", 32'(retire_count), 1);
    chk("dup_id", 32'(ids_retiring[0]), 4);
    step();
    chk("dup_empty", 32'(empty), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/retire_order_tracker.md
# retire_order_tracker

In-order retirement tracker that sits on the opposite side of ID allocation. It records instruction IDs in issue order and collects out-of-order writeback completions per ID. Each cycle it retires up to RETIRE_PORTS consecutive completed IDs from the head of the queue. Its `retired` / `ids_retiring` outputs drive the ID-freeing and register-file commit inputs of the metadata/ID manager.

## Interface
- MAX_IDS, 8: ID space size and queue depth; power of two, at least 4.
- WB_PORTS, 2: writeback completion ports.
- RETIRE_PORTS, 2: maximum retirements per cycle; at most MAX_IDS.
- ID_W, $clog2(MAX_IDS): ID width (derived).
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- issue_valid  in  1  an instruction issues this cycle.
- issue_id  in  ID_W  ID of the issuing instruction.
- issue_uses_rd  in  1  the instruction writes the register file.
- issue_ready  out  1  queue not full; registered-state only.
- wb_valid  in  [WB_PORTS]  completion strobe per port.
- wb_id  in  ID_W [WB_PORTS]  completing ID per port.
- retired  out  1 [RETIRE_PORTS]  retire strobe per port; contiguous from port 0.
- ids_retiring  out  ID_W [RETIRE_PORTS]  ID of queue entry head+k.
- retired_uses_rd  out  1 [RETIRE_PORTS]  uses_rd of the retiring entry.
- retire_count  out  $clog2(RETIRE_PORTS+1)  number of asserted `retired` bits.
- inflight_count  out  ID_W+1  current queue occupancy.
- empty  out  1  occupancy == 0.
- protocol_error  out  1  sticky error flag; cleared only by reset.

## Operation
- State:
  - circular queue of {id, uses_rd}, MAX_IDS entries;
  - head/tail pointers, ID_W bits, natural wrap;
  - count, ID_W+1 bits;
  - per-ID `inflight` and `done` bits.
- Enqueue: accepted when issue_valid & issue_ready & ~inflight[issue_id].
  - Writes entry[tail]; tail+1, sets inflight[issue_id], clears done[issue_id].
- Completion: each port with wb_valid & inflight[wb_id] & ~done[wb_id] sets done[wb_id].
  - Two ports naming the same legal ID in one cycle: done is set once, and protocol_error is set.
- Retire (combinational from registered state only):
  - retired[k] = retired[k-1] & (k < count) & done[entry[head+k].id], with retired[-1]=1.
  - On each retirement: clear inflight and done of that ID; head += retire_count.
- Occupancy: count_next = count + accepted_issue − retire_count.
  - Issue and retire in the same cycle are both honoured when issue_ready=1.
- Protocol errors: set protocol_error and have no other state effect:
  - issue_valid while ~issue_ready;
  - issue of an already-inflight ID;
  - wb of a non-inflight ID;
  - wb of an already-done ID;
  - duplicate same-cycle wb.

## Timing
- Reset values:
  - all outputs low except issue_ready=1 and empty=1;
  - head=tail=count=0;
  - all inflight/done bits 0; protocol_error 0.
- Reset is asynchronous. Asserting it mid-operation drops all queued IDs immediately; no retire strobes are issued for them.
- Completion latency: wb sampled at edge N makes retired visible in cycle N+1 if the entry is at head and all older entries are done. There is no same-cycle wb→retire bypass.
- Issue latency: an ID issued at edge N and completed at edge N+1 can retire at the earliest in cycle N+2.
- issue_ready = count < MAX_IDS, from registered count. A slot freed by a retire is visible the next cycle.
- Pointer wrap: head+k is taken modulo MAX_IDS.
- Full: issue_ready=0 until at least one retire.
- Empty: retired all zero.
- An ID retiring at edge N can be re-issued from cycle N+1.

## Test plan
- Reset: with rst_n low, then one idle cycle after release → issue_ready=1, empty=1, retire_count=0, protocol_error=0.
- In-order: issue IDs 0,1,2 on consecutive cycles, then wb 0,1,2 on both ports in pairs → retired[0..1] with ids_retiring={0,1}, retire_count=2; next cycle ID 2 with retire_count=1; then empty=1.
- Out-of-order: issue 0..3, complete 3,2,1 → no retire. Complete 0 → next cycle retire 0,1 (RETIRE_PORTS=2); following cycle retire 2,3.
- Full and wrap: issue IDs 0..7 → issue_ready=0.
  - Complete 0 → retire 0.
  - Same cycle issue_valid with ID 0 is rejected and protocol_error=1.
  - In the next cycle, issue ID 0 with issue_ready=1 → accepted at slot 0 (tail wrapped); inflight_count=8.
- Simultaneous issue+retire: count=3, issue ID 5 while 2 retire → inflight_count=2 next cycle.
- Errors and reset: wb of non-inflight ID 6 → protocol_error=1, no state change. Assert rst_n mid-stream with 4 inflight → all outputs return to reset values at once.
